// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RISC-V memory-access stage (req/ack dmem port, load extend, store lanes); optional MEM_MISALIGN_TRAP_EN
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        IN_LOAD,
  input  logic        IN_STORE,
  input  logic [2:0]  IN_FUNCT3,
  input  logic [31:0] IN_ADDR,
  input  logic [31:0] IN_WDATA,
  input  logic [4:0]  IN_RD,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_WSTRB,
  output logic [31:0] DMEM_WDATA,
  input  logic        DMEM_ACK,
  input  logic [31:0] DMEM_RDATA,
  output logic        OUT_VALID,
  output logic [4:0]  OUT_RD,
  output logic [31:0] MEMORY_OUT,
  output logic        OUT_ERR
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [1:0]           state;
  logic                 op_load;
  logic                 op_store;
  logic [2:0]           op_funct3;
  logic [31:0]          op_addr;
  logic [31:0]          op_wdata;
  logic [4:0]           op_rd;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic [CNT_WIDTH-1:0] wait_cnt_next;
  logic                 err_q;
  logic [31:0]          mem_out_q;

  logic                 in_illegal;
  logic                 in_misalign;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [31:0]          ld_data;
  logic [3:0]           st_strb;
  logic [31:0]          st_data;

  assign wait_cnt_next = wait_cnt + CNT_WIDTH'(1);

  // Classify the incoming op: conflicting load/store flags or unsupported size encodings
  always_comb begin
    in_illegal = 1'b0;
    if (IN_LOAD && IN_STORE)
      in_illegal = 1'b1;
    else if (IN_LOAD && (IN_FUNCT3 == 3'b011 || IN_FUNCT3[2:1] == 2'b11))
      in_illegal = 1'b1;
    else if (IN_STORE && (IN_FUNCT3[2] || IN_FUNCT3[1:0] == 2'b11))
      in_illegal = 1'b1;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Halfwords must be 2-byte aligned and words 4-byte aligned, otherwise trap without a request
  always_comb begin
    in_misalign = (IN_LOAD || IN_STORE) &&
                  ((IN_FUNCT3[1:0] == 2'b01 && IN_ADDR[0]) ||
                   (IN_FUNCT3[1:0] == 2'b10 && IN_ADDR[1:0] != 2'b00));
  end
`else
  assign in_misalign = 1'b0;
`endif

  // Pick the addressed lane out of the read word and extend it to 32 bits
  always_comb begin
    case (op_addr[1:0])
      2'd0:    ld_byte = DMEM_RDATA[7:0];
      2'd1:    ld_byte = DMEM_RDATA[15:8];
      2'd2:    ld_byte = DMEM_RDATA[23:16];
      default: ld_byte = DMEM_RDATA[31:24];
    endcase
    ld_half = op_addr[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
    case (op_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = DMEM_RDATA;
    endcase
  end

  // Store byte strobes and lane-replicated write data
  always_comb begin
    st_strb = 4'b0000;
    st_data = 32'h0;
    case (op_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << op_addr[1:0];
        st_data = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = op_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{op_wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = op_wdata;
      end
    endcase
  end

  // Port outputs decode straight from state so an async reset drops the request at once
  always_comb begin
    IN_READY   = (state == ST_IDLE);
    DMEM_REQ   = (state == ST_REQ);
    DMEM_WE    = DMEM_REQ && op_store;
    DMEM_ADDR  = DMEM_REQ ? {op_addr[31:2], 2'b00} : 32'h0;
    DMEM_WSTRB = DMEM_WE ? st_strb : 4'b0000;
    DMEM_WDATA = DMEM_WE ? st_data : 32'h0;
    OUT_VALID  = (state == ST_DONE);
    OUT_RD     = op_rd;
    MEMORY_OUT = mem_out_q;
    OUT_ERR    = err_q;
  end

  // Op capture, request/ack handshake with timeout, and result registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= ST_IDLE;
      op_load   <= 1'b0;
      op_store  <= 1'b0;
      op_funct3 <= 3'b000;
      op_addr   <= 32'h0;
      op_wdata  <= 32'h0;
      op_rd     <= 5'd0;
      wait_cnt  <= '0;
      err_q     <= 1'b0;
      mem_out_q <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (IN_VALID) begin
            op_load   <= IN_LOAD;
            op_store  <= IN_STORE;
            op_funct3 <= IN_FUNCT3;
            op_addr   <= IN_ADDR;
            op_wdata  <= IN_WDATA;
            op_rd     <= IN_RD;
            wait_cnt  <= '0;
            mem_out_q <= 32'h0;
            err_q     <= in_illegal || in_misalign;
            if ((IN_LOAD || IN_STORE) && !in_illegal && !in_misalign)
              state <= ST_REQ;
            else
              state <= ST_DONE;
          end
        end
        ST_REQ: begin
          if (DMEM_ACK) begin
            if (op_load)
              mem_out_q <= ld_data;
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt_next;
            if (TIMEOUT_CYCLES != 0 && wait_cnt_next == CNT_LIMIT) begin
              err_q     <= 1'b1;
              mem_out_q <= 32'h0;
              state     <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage against a behavioural model
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        IN_VALID, IN_READY, IN_LOAD, IN_STORE;
  logic [2:0]  IN_FUNCT3;
  logic [31:0] IN_ADDR, IN_WDATA;
  logic [4:0]  IN_RD;
  logic        DMEM_REQ, DMEM_WE, DMEM_ACK;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic [3:0]  DMEM_WSTRB;
  logic        OUT_VALID, OUT_ERR;
  logic [4:0]  OUT_RD;
  logic [31:0] MEMORY_OUT;

  int checks = 0;
  int failures = 0;

  int          obs_lat, obs_nreq;
  logic [31:0] obs_addr, obs_wdata, obs_mem;
  logic        obs_we, obs_err;
  logic [3:0]  obs_strb;
  logic [4:0]  obs_rd;

  mem_access_stage #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_LOAD(IN_LOAD), .IN_STORE(IN_STORE),
    .IN_FUNCT3(IN_FUNCT3), .IN_ADDR(IN_ADDR), .IN_WDATA(IN_WDATA), .IN_RD(IN_RD),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WSTRB(DMEM_WSTRB),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
    .OUT_VALID(OUT_VALID), .OUT_RD(OUT_RD), .MEMORY_OUT(MEMORY_OUT), .OUT_ERR(OUT_ERR)
  );

  always #5 CLK = ~CLK;

  // Issue one op, play memory with a given ack delay (<0 = never ack), compare against the model
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input int ack_delay, input logic [31:0] rdata);
    logic illegal, mis, is_mem, timeout, exp_err, done;
    logic [1:0]  sz;
    logic [31:0] exp_mem, exp_addr, exp_wdata, v;
    logic [3:0]  exp_strb;
    int exp_nreq, exp_lat;
    sz = f3[1:0];
    illegal = (ld && st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 > 2);
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((ld || st) && !illegal)
      mis = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
`endif
    is_mem   = (ld || st) && !illegal && !mis;
    timeout  = is_mem && (ack_delay < 0 || ack_delay >= TMO);
    exp_nreq = !is_mem ? 0 : (timeout ? TMO : ack_delay + 1);
    exp_lat  = exp_nreq + 1;
    exp_err  = illegal || mis || timeout;
    exp_addr = a & 32'hFFFF_FFFC;
    exp_mem  = 32'h0;
    if (ld && is_mem && !timeout) begin
      if (sz == 0) begin
        v = (rdata >> (8 * a[1:0])) & 32'hFF;
        if (!f3[2] && v >= 128) v = v | 32'hFFFF_FF00;
      end else if (sz == 1) begin
        v = (rdata >> (16 * a[1])) & 32'hFFFF;
        if (!f3[2] && v >= 32768) v = v | 32'hFFFF_0000;
      end else begin
        v = rdata;
      end
      exp_mem = v;
    end
    exp_strb  = 4'h0;
    exp_wdata = 32'h0;
    if (st && is_mem) begin
      if (sz == 0) begin
        exp_strb  = 4'(1 << a[1:0]);
        exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
      end else if (sz == 1) begin
        exp_strb  = a[1] ? 4'hC : 4'h3;
        exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      end else begin
        exp_strb  = 4'hF;
        exp_wdata = wd;
      end
    end

    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL in_ready_before_accept: got %b expected 1", IN_READY);
    end
    IN_VALID = 1'b1; IN_LOAD = ld; IN_STORE = st; IN_FUNCT3 = f3;
    IN_ADDR = a; IN_WDATA = wd; IN_RD = rd;
    DMEM_ACK = 1'($urandom_range(0, 1));
    DMEM_RDATA = $urandom;
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_LOAD = 1'($urandom_range(0, 1)); IN_STORE = 1'($urandom_range(0, 1));
    IN_ADDR = $urandom; IN_WDATA = $urandom;
    obs_lat = 0; obs_nreq = 0; done = 1'b0;
    obs_addr = 32'h0; obs_we = 1'b0; obs_strb = 4'h0; obs_wdata = 32'h0;
    for (int k = 1; k <= 20 && !done; k++) begin
      DMEM_ACK = 1'b0;
      DMEM_RDATA = $urandom;
      if (OUT_VALID) begin
        obs_lat = k;
        done = 1'b1;
        DMEM_ACK = 1'($urandom_range(0, 1));
      end else begin
        if (DMEM_REQ) begin
          if (obs_nreq == 0) begin
            obs_addr = DMEM_ADDR; obs_we = DMEM_WE; obs_strb = DMEM_WSTRB; obs_wdata = DMEM_WDATA;
          end
          checks++;
          if ({DMEM_ADDR, DMEM_WE, DMEM_WSTRB, DMEM_WDATA} !== {exp_addr, st, exp_strb, exp_wdata}) begin
            failures++;
            $display("FAIL dmem_fields: got addr=%h we=%b strb=%b wdata=%h expected addr=%h we=%b strb=%b wdata=%h",
                     DMEM_ADDR, DMEM_WE, DMEM_WSTRB, DMEM_WDATA, exp_addr, st, exp_strb, exp_wdata);
          end
          if (obs_nreq == ack_delay) begin
            DMEM_ACK = 1'b1;
            DMEM_RDATA = rdata;
          end
          obs_nreq++;
        end
        @(negedge CLK);
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL out_valid_wait: got no OUT_VALID within 20 cycles expected latency %0d", exp_lat);
    end else begin
      obs_mem = MEMORY_OUT; obs_err = OUT_ERR; obs_rd = OUT_RD;
      checks++;
      if (obs_lat != exp_lat) begin
        failures++;
        $display("FAIL latency: got %0d expected %0d", obs_lat, exp_lat);
      end
      checks++;
      if (obs_nreq != exp_nreq) begin
        failures++;
        $display("FAIL req_cycles: got %0d expected %0d", obs_nreq, exp_nreq);
      end
      checks++;
      if ({MEMORY_OUT, OUT_ERR, OUT_RD} !== {exp_mem, exp_err, rd}) begin
        failures++;
        $display("FAIL result: got mem=%h err=%b rd=%0d expected mem=%h err=%b rd=%0d",
                 MEMORY_OUT, OUT_ERR, OUT_RD, exp_mem, exp_err, rd);
      end
      @(negedge CLK);
      DMEM_ACK = 1'b0;
      checks++;
      if ({OUT_VALID, IN_READY, DMEM_REQ, MEMORY_OUT, OUT_ERR} !== {1'b0, 1'b1, 1'b0, exp_mem, exp_err}) begin
        failures++;
        $display("FAIL after_done: got valid=%b ready=%b req=%b mem=%h err=%b expected valid=0 ready=1 req=0 mem=%h err=%b",
                 OUT_VALID, IN_READY, DMEM_REQ, MEMORY_OUT, OUT_ERR, exp_mem, exp_err);
      end
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0; IN_VALID = 1'b0; IN_LOAD = 1'b0; IN_STORE = 1'b0; IN_FUNCT3 = 3'b0;
    IN_ADDR = 32'h0; IN_WDATA = 32'h0; IN_RD = 5'd0; DMEM_ACK = 1'b0; DMEM_RDATA = 32'h0;
    @(negedge CLK);
    checks++;
    if ({IN_READY, DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WSTRB, DMEM_WDATA, OUT_VALID, OUT_RD, MEMORY_OUT, OUT_ERR}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got ready=%b req=%b we=%b addr=%h valid=%b rd=%0d mem=%h err=%b expected ready=1 and all else 0",
               IN_READY, DMEM_REQ, DMEM_WE, DMEM_ADDR, OUT_VALID, OUT_RD, MEMORY_OUT, OUT_ERR);
    end
    RSTN = 1'b1;
  endtask

  task automatic test_lb();
    run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd3, 0, 32'h80AA_BBCC);
    checks++;
    if ({obs_addr, obs_mem, 32'(obs_lat)} !== {32'h100, 32'hFFFF_FF80, 32'd2}) begin
      failures++;
      $display("FAIL lb_case: got addr=%h mem=%h lat=%0d expected addr=00000100 mem=ffffff80 lat=2",
               obs_addr, obs_mem, obs_lat);
    end
  endtask

  task automatic test_lhu_wait();
    run_op(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 5'd9, 3, 32'hBEEF_1234);
    checks++;
    if ({obs_addr, obs_mem, 32'(obs_nreq), obs_err} !== {32'h200, 32'h0000_BEEF, 32'd4, 1'b0}) begin
      failures++;
      $display("FAIL lhu_case: got addr=%h mem=%h nreq=%0d err=%b expected addr=00000200 mem=0000beef nreq=4 err=0",
               obs_addr, obs_mem, obs_nreq, obs_err);
    end
  endtask

  task automatic test_sb();
    run_op(1'b0, 1'b1, 3'b000, 32'h301, 32'h1234_56A5, 5'd4, 1, 32'h0);
    checks++;
    if ({obs_we, obs_strb, obs_wdata, obs_mem, obs_err} !== {1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL sb_case: got we=%b strb=%b wdata=%h mem=%h err=%b expected we=1 strb=0010 wdata=a5a5a5a5 mem=0 err=0",
               obs_we, obs_strb, obs_wdata, obs_mem, obs_err);
    end
  endtask

  task automatic test_timeout();
    run_op(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd5, -1, 32'h0);
    checks++;
    if ({32'(obs_nreq), obs_err, obs_mem, 32'(obs_lat)} !== {32'd4, 1'b1, 32'h0, 32'd5}) begin
      failures++;
      $display("FAIL timeout_case: got nreq=%0d err=%b mem=%h lat=%0d expected nreq=4 err=1 mem=0 lat=5",
               obs_nreq, obs_err, obs_mem, obs_lat);
    end
  endtask

  task automatic test_misalign();
    run_op(1'b0, 1'b1, 3'b010, 32'h402, 32'hCAFE_F00D, 5'd6, 0, 32'h0);
    checks++;
`ifdef MEM_MISALIGN_TRAP_EN
    if ({32'(obs_nreq), obs_err} !== {32'd0, 1'b1}) begin
      failures++;
      $display("FAIL sw_misalign: got nreq=%0d err=%b expected nreq=0 err=1", obs_nreq, obs_err);
    end
`else
    if ({32'(obs_nreq), obs_strb, obs_addr, obs_err} !== {32'd1, 4'hF, 32'h400, 1'b0}) begin
      failures++;
      $display("FAIL sw_misalign: got nreq=%0d strb=%b addr=%h err=%b expected nreq=1 strb=1111 addr=00000400 err=0",
               obs_nreq, obs_strb, obs_addr, obs_err);
    end
`endif
  endtask

  task automatic test_illegal();
    run_op(1'b1, 1'b1, 3'b000, 32'h700, 32'h0, 5'd8, 0, 32'h0);
    checks++;
    if ({32'(obs_nreq), obs_err, 32'(obs_lat)} !== {32'd0, 1'b1, 32'd1}) begin
      failures++;
      $display("FAIL illegal_both: got nreq=%0d err=%b lat=%0d expected nreq=0 err=1 lat=1", obs_nreq, obs_err, obs_lat);
    end
    run_op(1'b1, 1'b0, 3'b011, 32'h704, 32'h0, 5'd8, 0, 32'h0);
    run_op(1'b0, 1'b1, 3'b100, 32'h708, 32'h0, 5'd8, 0, 32'h0);
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    IN_VALID = 1'b1; IN_LOAD = 1'b1; IN_STORE = 1'b0; IN_FUNCT3 = 3'b010;
    IN_ADDR = 32'h500; IN_RD = 5'd2;
    @(negedge CLK);
    IN_VALID = 1'b0;
    DMEM_ACK = 1'b0;
    checks++;
    if (DMEM_REQ !== 1'b1) begin
      failures++;
      $display("FAIL mid_req_up: got %b expected 1", DMEM_REQ);
    end
    @(negedge CLK);
    RSTN = 1'b0;
    #1;
    checks++;
    if ({DMEM_REQ, OUT_VALID, IN_READY} !== 3'b001) begin
      failures++;
      $display("FAIL mid_reset_drop: got req=%b valid=%b ready=%b expected req=0 valid=0 ready=1",
               DMEM_REQ, OUT_VALID, IN_READY);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if ({OUT_VALID, DMEM_REQ} !== 2'b00) begin
        failures++;
        $display("FAIL mid_reset_quiet: got valid=%b req=%b expected 00", OUT_VALID, DMEM_REQ);
      end
    end
    run_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd7, 0, 32'h0);
    checks++;
    if ({32'(obs_lat), obs_rd, obs_mem} !== {32'd1, 5'd7, 32'h0}) begin
      failures++;
      $display("FAIL passthrough_after_reset: got lat=%0d rd=%0d mem=%h expected lat=1 rd=7 mem=0",
               obs_lat, obs_rd, obs_mem);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      run_op(r < 4 || r == 9, (r >= 4 && r < 8) || r == 9, 3'($urandom_range(0, 7)),
             $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 5), $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lb();
    test_lhu_wait();
    test_sb();
    test_timeout();
    test_misalign();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the RISC-V pipeline; sits between execute and writeback.
- Takes the decoded load/store op, the execute result (effective address) and store data.
- Runs a req/ack transaction on the data-memory port, aligns and sign/zero-extends load data, and presents MEMORY_OUT plus a valid strobe to the writeback stage.
- Non-memory ops pass through with one register stage so writeback timing is uniform.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles DMEM_REQ is held without DMEM_ACK before abort; 0 disables the timeout.
- CNT_WIDTH, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- IN_VALID  in  1  execute presents an op.
- IN_READY  out  1  stage can accept; high only in IDLE.
- IN_LOAD  in  1  op is lb/lh/lw/lbu/lhu.
- IN_STORE  in  1  op is sb/sh/sw.
- IN_FUNCT3  in  3  RISC-V funct3 (size/sign).
- IN_ADDR  in  32  effective address (execute result).
- IN_WDATA  in  32  rs2 store data.
- IN_RD  in  5  destination register.
- DMEM_REQ  out  1  memory request.
- DMEM_WE  out  1  1 = write.
- DMEM_ADDR  out  32  word address {addr[31:2],2'b00}.
- DMEM_WSTRB  out  4  byte strobes.
- DMEM_WDATA  out  32  lane-replicated store data.
- DMEM_ACK  in  1  memory completes the request this cycle.
- DMEM_RDATA  in  32  read word; valid when DMEM_ACK=1.
- OUT_VALID  out  1  one-cycle strobe to writeback.
- OUT_RD  out  5  registered IN_RD.
- MEMORY_OUT  out  32  extended load data; 0 for stores, non-memory ops and errors.
- OUT_ERR  out  1  illegal, misaligned or timed-out access; valid with OUT_VALID.

Behaviour:
- Reset (RSTN=0, async): state IDLE; all outputs 0 except IN_READY=1; timeout counter 0.
- Reset mid-transaction drops DMEM_REQ immediately and discards the op.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Accept when IN_VALID & IN_READY; register all inputs.
  - Neither load nor store → DONE.
  - Load with legal funct3, or store with legal funct3 → REQ.
  - Illegal op → DONE with OUT_ERR=1. Illegal means: both IN_LOAD and IN_STORE set; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
- REQ:
  - DMEM_REQ=1; DMEM_WE/ADDR/WSTRB/WDATA held stable until DMEM_ACK is sampled high. ACK in the first REQ cycle is legal.
  - On ACK: a load latches extracted DMEM_RDATA into MEMORY_OUT; go to DONE.
  - Counter increments each REQ cycle without ACK. When it reaches TIMEOUT_CYCLES (if non-zero): drop REQ, OUT_ERR=1, MEMORY_OUT=0, go to DONE.
  - ACK in the same cycle the count reaches the limit counts as success.
- DONE: OUT_VALID=1 for exactly one cycle; then IDLE. OUT_ERR and MEMORY_OUT hold until the next accept.
- DMEM_ACK outside REQ is ignored.
- Latency:
  - Pass-through: OUT_VALID one cycle after accept.
  - Memory op: accept at T, REQ at T+1, ACK at T+1+n, OUT_VALID at T+2+n.
  - Throughput is one op per 2 cycles minimum, since IN_READY is low in REQ/DONE.
- Load extraction: byte lane = addr[1:0]; half lane = addr[1].
  - lb: sign-extend byte. lbu: zero-extend byte.
  - lh: sign-extend halfword. lhu: zero-extend halfword.
  - lw: whole word.
- Store strobes and data:
  - sb: WSTRB = 4'b0001 << addr[1:0]; WDATA = {4{wdata[7:0]}}.
  - sh: WSTRB = addr[1] ? 4'b1100 : 4'b0011; WDATA = {2{wdata[15:0]}}.
  - sw: WSTRB = 4'b1111; WDATA = wdata.
- Loads drive WSTRB=0 and WDATA=0.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]≠0, issues no request and goes IDLE→DONE with OUT_ERR=1 and MEMORY_OUT=0.
- Undefined: no misalignment check. Halfword lane uses addr[1] only; word ignores addr[1:0]. The access proceeds normally with OUT_ERR=0.

Test Plan:
- lb at addr 0x103, DMEM_RDATA=0x80AABBCC, ACK in first REQ cycle → DMEM_ADDR=0x100; MEMORY_OUT=0xFFFFFF80; OUT_VALID exactly 2 cycles after accept.
- lhu at addr 0x202, RDATA=0xBEEF1234, ACK after 3 wait cycles → REQ held 4 cycles with stable address; MEMORY_OUT=0x0000BEEF.
- sb at addr 0x301, IN_WDATA=0x123456A5 → WE=1, WSTRB=0010, WDATA=0xA5A5A5A5; MEMORY_OUT=0; OUT_ERR=0.
- TIMEOUT_CYCLES=4, lw with ACK never asserted → REQ high for 4 cycles then low; OUT_VALID=1 with OUT_ERR=1 and MEMORY_OUT=0.
- sw at addr 0x402 → with MEM_MISALIGN_TRAP_EN: no DMEM_REQ, OUT_ERR=1. Without it: WSTRB=1111 at 0x400, OUT_ERR=0.
- RSTN pulsed low during REQ of lw at 0x500 → DMEM_REQ=0 immediately, no OUT_VALID; after release, add op with IN_RD=7 accepted → OUT_VALID next cycle, OUT_RD=7, MEMORY_OUT=0.
